// File: rtl/seq_pkg.sv
// Shared encodings for the CPU instruction sequencer: state codes, opcodes,
// ALU function select and the decode result record.
package seq_pkg;

  localparam int INSTR_W           = 23;
  localparam int STATE_W           = 5;
  localparam int DEF_FETCH_TIMEOUT = 15;
  localparam int DEF_TO_W          = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 5'b00000,
    ST_LOAD   = 5'b00001,
    ST_MOV    = 5'b00010,
    ST_AR1    = 5'b00011,
    ST_AR2    = 5'b00100,
    ST_AR3    = 5'b00101,
    ST_NOP    = 5'b00110,
    ST_LATCH  = 5'b01000,
    ST_FETCH  = 5'b10000,
    ST_FAULT  = 5'b11110,
    ST_HALTED = 5'b11111
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_MOV  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_XOR  = 3'b101,
    OP_NOP  = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  // Decode of one opcode: where LATCH goes next and whether alu_op reloads.
  typedef struct packed {
    state_e  nxt;
    logic    alu_ld;
    alu_op_e alu_op;
  } dec_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decode: next sequencer state and ALU function.
module seq_decode
  import seq_pkg::*;
(
  input  logic [2:0] opcode,
  output dec_t       dec
);

  logic [2:0] op_m2;

  always_comb begin
    op_m2      = opcode - 3'd2;
    dec.nxt    = ST_FAULT;
    dec.alu_ld = 1'b0;
    dec.alu_op = alu_op_e'(op_m2[1:0]);
    case (opcode_e'(opcode))
      OP_LOAD: dec.nxt = ST_LOAD;
      OP_MOV:  dec.nxt = ST_MOV;
      OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
        dec.nxt    = ST_AR1;
        dec.alu_ld = 1'b1;
      end
      OP_NOP:  dec.nxt = ST_NOP;
      OP_HALT: dec.nxt = ST_HALTED;
      default: dec.nxt = ST_FAULT;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Control FSM for the simple CPU: instruction latch, per-opcode sequencing,
// fetch watchdog. Define SEQ_INSTR_COUNT_EN to add the retired_cnt output.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int FETCH_TIMEOUT = DEF_FETCH_TIMEOUT,
  parameter int TO_W          = DEF_TO_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic [STATE_W-1:0] state,
  output logic [INSTR_W-1:0] ir,
  output logic [1:0]         alu_op,
  output logic               busy,
  output logic               retire,
  output logic               halted,
`ifdef SEQ_INSTR_COUNT_EN
  output logic               fault,
  output logic [15:0]        retired_cnt
`else
  output logic               fault
`endif
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(FETCH_TIMEOUT);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  alu_op_e            alu_q, alu_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d, to_inc;
  dec_t               dec;

  seq_decode u_dec (
    .opcode (instr_in[22:20]),
    .dec    (dec)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    alu_d    = alu_q;
    to_cnt_d = '0;
    to_inc   = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_LATCH;
      // run=0 wins over a simultaneous instr_valid so stop is deterministic
      ST_LATCH: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (instr_valid) begin
          ir_d    = instr_in;
          state_d = dec.nxt;
          if (dec.alu_ld) alu_d = dec.alu_op;
        end else begin
          to_cnt_d = to_inc;
          if (to_inc >= TO_LIMIT) state_d = ST_FAULT;
        end
      end
      ST_LOAD, ST_MOV, ST_NOP: state_d = ST_FETCH;
      ST_AR1:   state_d = ST_AR2;
      ST_AR2:   state_d = ST_AR3;
      // AR3 already steps the PC, so no FETCH before the next latch
      ST_AR3:   state_d = ST_LATCH;
      ST_FETCH: state_d = ST_LATCH;
      ST_FAULT, ST_HALTED: if (!run) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      alu_q    <= ALU_ADD;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      alu_q    <= alu_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign state  = state_q;
  assign ir     = ir_q;
  assign alu_op = alu_q;
  assign retire = (state_q inside {ST_LOAD, ST_MOV, ST_AR3, ST_NOP});
  assign busy   = !(state_q inside {ST_IDLE, ST_HALTED, ST_FAULT});
  assign halted = (state_q == ST_HALTED);
  assign fault  = (state_q == ST_FAULT);

`ifdef SEQ_INSTR_COUNT_EN
  logic [15:0] rcnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 rcnt_q <= '0;
    else if (state_q == ST_IDLE && run)           rcnt_q <= '0;
    else if (retire && rcnt_q != 16'hFFFF)        rcnt_q <= rcnt_q + 16'd1;
  end

  assign retired_cnt = rcnt_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: expected per-cycle outputs are queued
// as stimulus is applied and checked one cycle later.
module tb_instr_sequencer;

  localparam logic [4:0] S_IDLE = 5'b00000, S_LOAD = 5'b00001, S_MOV = 5'b00010,
                         S_AR1 = 5'b00011, S_AR2 = 5'b00100, S_AR3 = 5'b00101,
                         S_NOP = 5'b00110, S_LATCH = 5'b01000, S_FETCH = 5'b10000,
                         S_FAULT = 5'b11110, S_HALT = 5'b11111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [22:0] instr_in;
  logic        instr_valid;
  logic [4:0]  state;
  logic [22:0] ir;
  logic [1:0]  alu_op;
  logic        busy, retire, halted, fault;
`ifdef SEQ_INSTR_COUNT_EN
  logic [15:0] retired_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];

  instr_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .state       (state),
    .ir          (ir),
    .alu_op      (alu_op),
    .busy        (busy),
    .retire      (retire),
    .halted      (halted),
`ifdef SEQ_INSTR_COUNT_EN
    .fault       (fault),
    .retired_cnt (retired_cnt)
`else
    .fault       (fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] ex(logic [4:0] st, logic ret, logic bsy,
                                     logic hlt, logic flt, logic [1:0] op);
    return {st, ret, bsy, hlt, flt, op};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    assert (got === want)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
  endtask

  // Queue expectation, clock once, compare against the oldest entry.
  task automatic step(string tag, logic [10:0] e);
    logic [10:0] want;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(tag, {21'd0, state, retire, busy, halted, fault, alu_op}, {21'd0, want});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; run = 1'b0; instr_valid = 1'b0; instr_in = '0;
    #3;
    check("reset_outs", {21'd0, state, retire, busy, halted, fault, alu_op}, 32'd0);
    check("reset_ir", {9'd0, ir}, 32'd0);
`ifdef SEQ_INSTR_COUNT_EN
    check("reset_cnt", {16'd0, retired_cnt}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1; run = 1'b1; instr_valid = 1'b1; instr_in = 23'h000000;

    // LOAD
    step("load_latch", ex(S_LATCH, 0, 1, 0, 0, 2'b00));
    step("load_exec",  ex(S_LOAD,  1, 1, 0, 0, 2'b00));
    step("load_fetch", ex(S_FETCH, 0, 1, 0, 0, 2'b00));
    step("load_relat", ex(S_LATCH, 0, 1, 0, 0, 2'b00));
    // ADD
    instr_in = 23'h280000;
    step("add_ar1", ex(S_AR1,   0, 1, 0, 0, 2'b00));
    step("add_ar2", ex(S_AR2,   0, 1, 0, 0, 2'b00));
    step("add_ar3", ex(S_AR3,   1, 1, 0, 0, 2'b00));
    step("add_lat", ex(S_LATCH, 0, 1, 0, 0, 2'b00));
    // SUB
    instr_in = 23'h300000;
    step("sub_ar1", ex(S_AR1,   0, 1, 0, 0, 2'b01));
    check("sub_ir", {9'd0, ir}, 32'h300000);
    step("sub_ar2", ex(S_AR2,   0, 1, 0, 0, 2'b01));
    step("sub_ar3", ex(S_AR3,   1, 1, 0, 0, 2'b01));
    step("sub_lat", ex(S_LATCH, 0, 1, 0, 0, 2'b01));
    // Fetch timeout: 15 LATCH cycles total then FAULT
    instr_valid = 1'b0;
    for (int i = 1; i < 15; i++) step("to_wait", ex(S_LATCH, 0, 1, 0, 0, 2'b01));
    step("to_fault", ex(S_FAULT, 0, 0, 0, 1, 2'b01));
    step("fault_hold", ex(S_FAULT, 0, 0, 0, 1, 2'b01));
    run = 1'b0;
    step("fault_idle", ex(S_IDLE, 0, 0, 0, 0, 2'b01));
    step("idle_hold",  ex(S_IDLE, 0, 0, 0, 0, 2'b01));
    // HALT
    run = 1'b1; instr_valid = 1'b1; instr_in = 23'h700000;
    step("halt_lat",  ex(S_LATCH, 0, 1, 0, 0, 2'b01));
    step("halt_ent",  ex(S_HALT,  0, 0, 1, 0, 2'b01));
    step("halt_hold", ex(S_HALT,  0, 0, 1, 0, 2'b01));
    run = 1'b0;
    step("halt_idle", ex(S_IDLE,  0, 0, 0, 0, 2'b01));
    // AND with run dropped in AR2
    run = 1'b1; instr_in = 23'h400000;
    step("and_lat", ex(S_LATCH, 0, 1, 0, 0, 2'b01));
    step("and_ar1", ex(S_AR1,   0, 1, 0, 0, 2'b10));
    step("and_ar2", ex(S_AR2,   0, 1, 0, 0, 2'b10));
    run = 1'b0;
    step("drop_ar3",  ex(S_AR3,   1, 1, 0, 0, 2'b10));
    step("drop_lat",  ex(S_LATCH, 0, 1, 0, 0, 2'b10));
    step("drop_idle", ex(S_IDLE,  0, 0, 0, 0, 2'b10));
    // XOR, then async reset in AR1
    run = 1'b1; instr_in = 23'h500000;
    step("xor_lat", ex(S_LATCH, 0, 1, 0, 0, 2'b10));
    step("xor_ar1", ex(S_AR1,   0, 1, 0, 0, 2'b11));
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_outs", {21'd0, state, retire, busy, halted, fault, alu_op}, 32'd0);
    check("async_rst_ir", {9'd0, ir}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; instr_in = 23'h100000;
    // 5 x MOV
    step("mov_lat0", ex(S_LATCH, 0, 1, 0, 0, 2'b00));
    for (int i = 0; i < 5; i++) begin
      step("mov_exec",  ex(S_MOV,   1, 1, 0, 0, 2'b00));
      step("mov_fetch", ex(S_FETCH, 0, 1, 0, 0, 2'b00));
      step("mov_lat",   ex(S_LATCH, 0, 1, 0, 0, 2'b00));
    end
`ifdef SEQ_INSTR_COUNT_EN
    check("retired_cnt", {16'd0, retired_cnt}, 32'd5);
`endif
    // NOP
    instr_in = 23'h600000;
    step("nop_exec",  ex(S_NOP,   1, 1, 0, 0, 2'b00));
    check("nop_ir", {9'd0, ir}, 32'h600000);
    step("nop_fetch", ex(S_FETCH, 0, 1, 0, 0, 2'b00));
    step("nop_lat",   ex(S_LATCH, 0, 1, 0, 0, 2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
